// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer.
// A single W-bit ripple adder (fa_n) is reused for N cycles, least-significant
// chunk first, to add two W*N-bit operands plus a carry-in. The carry is held
// in a register between chunks. Requests and results use valid/ready handshakes.

// W-bit adder with carry-in and carry-out
module fa_n #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out
);

    logic [W:0] total_s;

    // Zero-extend both operands so the top bit of the result is the carry-out
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        s       = total_s[W-1:0];
        c_out   = total_s[W];
    end

endmodule

module mp_add_seq #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*N-1:0] a_in,
    input  logic [W*N-1:0] b_in,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*N-1:0] sum,
    output logic           c_out
);

    // One extra bit keeps the counter legal (non-zero width) when N == 1
    localparam int IW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IW-1:0]    idx_r;
    logic             carry_r;
    logic [W*N-1:0]   a_r;
    logic [W*N-1:0]   b_r;
    logic [W*N-1:0]   sum_r;
    logic             c_out_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             last_chunk_s;
    logic [W-1:0]     a_chunk_s;
    logic [W-1:0]     b_chunk_s;
    logic [W-1:0]     fa_sum_s;
    logic             fa_carry_s;

    // Select the current chunk of each latched operand for the shared adder
    always_comb begin
        a_chunk_s    = a_r[int'(idx_r)*W +: W];
        b_chunk_s    = b_r[int'(idx_r)*W +: W];
        last_chunk_s = (idx_r == IW'(N - 1));
    end

    fa_n #(
        .W (W)
    ) u_fa (
        .a     (a_chunk_s),
        .b     (b_chunk_s),
        .c_in  (carry_r),
        .s     (fa_sum_s),
        .c_out (fa_carry_s)
    );

    // State register; reset wins over everything, discarding any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_chunk_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then one chunk per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= {IW{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {(W*N){1'b0}};
            b_r     <= {(W*N){1'b0}};
            sum_r   <= {(W*N){1'b0}};
            c_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a_in;
                        b_r     <= b_in;
                        carry_r <= c_in;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[int'(idx_r)*W +: W] <= fa_sum_s;
                    carry_r                   <= fa_carry_s;
                    idx_r                     <= idx_r + IW'(1);
                    if (last_chunk_s) begin
                        c_out_r <= fa_carry_s;
                    end
                end
                ST_DONE: begin
                    // Result held stable until the consumer takes it
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign sum       = sum_r;
    assign c_out     = c_out_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed testbench for mp_add_seq: a W=16/N=4 instance and a W=16/N=1 instance.
module tb_mp_add_seq;

    logic        clk;
    logic        rst;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
    logic [63:0] a4, b4, sum4;

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [15:0] a1, b1, sum1;

    int n_checks;
    int n_fail;

    mp_add_seq #(.W(16), .N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a_in      (a4),
        .b_in      (b4),
        .c_in      (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .c_out     (cout4)
    );

    mp_add_seq #(.W(16), .N(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a1),
        .b_in      (b1),
        .c_in      (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the N=4 instance and wait (bounded) for its result.
    // lat counts edges from the accept edge to out_valid. If release is set the
    // result is taken with a one-cycle out_ready pulse.
    task automatic run_op4(input logic [63:0] a, input logic [63:0] b, input logic c,
                           input bit release_res,
                           output logic [63:0] s, output logic co, output int lat);
        int guard;
        a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
        guard = 0;
        while (!in_ready4 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        s  = sum4;
        co = cout4;
        if (release_res) begin
            out_ready4 = 1'b1;
            tick();
            out_ready4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready4, out_valid4, cout4} !== 3'b100 || sum4 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_n4: rdy/vld/cout=%b sum=%h expected 100 sum=0",
                     {in_ready4, out_valid4, cout4}, sum4);
        end
        n_checks++;
        if ({in_ready1, out_valid1, cout1} !== 3'b100 || sum1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_n1: rdy/vld/cout=%b sum=%h expected 100 sum=0",
                     {in_ready1, out_valid1, cout1}, sum1);
        end
    endtask

    task automatic test_full_carry();
        logic [63:0] s;
        logic        co;
        int          lat;
        run_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 64'd0 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_sum: got sum=%h cout=%b expected sum=0 cout=1", s, co);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL t1_latency: got %0d edges expected 4", lat);
        end
    endtask

    task automatic test_cross_chunk();
        logic [63:0] s;
        logic        co;
        int          lat;
        run_op4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 64'h0000_0000_0001_0000 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_sum: got sum=%h cout=%b expected sum=0000000000010000 cout=0", s, co);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] s;
        logic        co;
        int          lat;
        run_op4(64'd42, 64'd5, 1'b1, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 64'd48 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_first: got sum=%0d cout=%b expected 48 cout=0", s, co);
        end
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_ready_after_done: got in_ready=%b expected 1", in_ready4);
        end
        run_op4(64'd10, 64'd23, 1'b0, 1'b0, s, co, lat);
        n_checks++;
        if (s !== 64'd33 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_second: got sum=%0d cout=%b expected 33 cout=0", s, co);
        end
    endtask

    // Continues from the unreleased result left by test_back_to_back
    task automatic test_backpressure();
        a4 = 64'd1000; b4 = 64'd2000; cin4 = 1'b0;
        in_valid4 = 1'b1;
        out_ready4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid4 !== 1'b1 || sum4 !== 64'd33 || in_ready4 !== 1'b0) begin
                n_fail++;
                $display("FAIL t4_hold cycle %0d: vld=%b sum=%0d rdy=%b expected vld=1 sum=33 rdy=0",
                         i, out_valid4, sum4, in_ready4);
            end
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        tick();
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_not_accepted: rdy=%b vld=%b expected rdy=1 vld=0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] s;
        logic        co;
        int          lat;
        bit          seen;
        a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'hFFFF_FFFF_FFFF_FFFF; cin4 = 1'b1;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready4, out_valid4, cout4} !== 3'b100 || sum4 !== 64'd0) begin
            n_fail++;
            $display("FAIL t5_reset: rdy/vld/cout=%b sum=%h expected 100 sum=0",
                     {in_ready4, out_valid4, cout4}, sum4);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid4) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_discarded: out_valid seen=%b expected 0", seen);
        end
        run_op4(64'd90, 64'd170, 1'b1, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 64'd261 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_after: got sum=%0d cout=%b expected 261 cout=0", s, co);
        end
    endtask

    task automatic test_n1();
        int lat;
        a1 = 16'hFFFF; b1 = 16'hFFFF; cin1 = 1'b0;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (sum1 !== 16'hFFFE || cout1 !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_sum: got sum=%h cout=%b expected fffe cout=1", sum1, cout1);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL t6_latency: got %0d edges expected 1", lat);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        n_checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_release: rdy=%b vld=%b expected rdy=1 vld=0", in_ready1, out_valid1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 64'd0; b4 = 64'd0; cin4 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 16'd0; b1 = 16'd0; cin1 = 1'b0;
        test_reset();
        test_full_carry();
        test_cross_chunk();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
